rf_wb_scheduler: RTL and testbench

Write-back scheduler and scoreboard for the 32x32 register file. Two write-back sources (single-cycle ALU path and a multi-cycle load/mul path) share the file's single write port through a round-robin arbiter with valid/ready handshakes. A pending-write scoreboard stalls issue on RAW and WAW hazards. It sits between the execute stage and the register file, and drives `we3`/`a3`/`wd3` from registers.

---
 rtl/rf_wb_scheduler.sv | 93 +++++++++
 tb/tb_rf_wb_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler for the 32x32 register file: round-robin arbitration of two
// write-back sources onto one registered write port, plus a pending-write scoreboard.
module rf_wb_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic        iss_wr,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  output logic        iss_ready,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [31:0] busy
);

  logic [31:0] busy_reg;
  logic [31:0] busy_next;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        we3_reg;
  logic [4:0]  a3_reg;
  logic [31:0] wd3_reg;
  logic        last_reg;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        iss_fire;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;

  // busy_reg[0] never gets set, so x0 lookups cannot stall issue.
  assign iss_ready = !(busy_reg[iss_rs1] | busy_reg[iss_rs2] | (iss_wr & busy_reg[iss_rd]));
  assign iss_fire  = iss_valid & iss_ready;

  // last_reg names the most recent winner; on contention the other requester wins.
  assign grant0   = req0_valid & (!req1_valid | last_reg);
  assign grant1   = req1_valid & (!req0_valid | !last_reg);
  assign accept   = grant0 | grant1;
  assign acc_rd   = grant1 ? req1_rd : req0_rd;
  assign acc_data = grant1 ? req1_data : req0_data;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign set_vec[0]   = 1'b0;
  assign clr_vec[0]   = 1'b0;
  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign set_vec[gi]   = iss_fire & iss_wr & (iss_rd == 5'(gi));
      // Clear coincides with the edge at which the register file stores the value.
      assign clr_vec[gi]   = we3_reg & (a3_reg == 5'(gi));
      assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= 32'd0;
      we3_reg  <= 1'b0;
      a3_reg   <= 5'd0;
      wd3_reg  <= 32'd0;
      last_reg <= 1'b1;
    end else begin
      busy_reg <= busy_next;
      we3_reg  <= accept & (acc_rd != 5'd0);
      if (accept) begin
        a3_reg   <= acc_rd;
        wd3_reg  <= acc_data;
        last_reg <= grant1;
      end
    end
  end

  assign we3  = we3_reg;
  assign a3   = a3_reg;
  assign wd3  = wd3_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios plus a randomized run against a
// cycle-level reference model of the scoreboard, arbiter and write port.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iss_valid = 1'b0, iss_wr = 1'b0;
  logic [4:0]  iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
  logic        iss_ready;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_rd = '0, req1_rd = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          mdl_busy[32];
  int          mdl_last = 1;
  bit          mdl_we = 1'b0;
  logic [4:0]  mdl_a3 = '0;
  logic [31:0] mdl_wd = '0;

  always #5 clk = ~clk;

  rf_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ready(iss_ready),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
  );

  function automatic logic [31:0] mdl_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mdl_busy[i];
    return v;
  endfunction

  function automatic bit mdl_iss_ready();
    return !(mdl_busy[iss_rs1] || mdl_busy[iss_rs2] || (iss_wr && mdl_busy[iss_rd]));
  endfunction

  // -1 = no grant, else index of granted requester
  function automatic int mdl_grant();
    if (req0_valid && req1_valid) return (mdl_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Advance one clock edge and move the model with it.
  task automatic tick();
    int          g;
    bit          ir, rst, iv, iw;
    logic [4:0]  rd, ird;
    logic [31:0] d;
    g   = mdl_grant();
    ir  = mdl_iss_ready();
    rst = reset;
    iv  = iss_valid;
    iw  = iss_wr;
    ird = iss_rd;
    rd  = (g == 1) ? req1_rd : req0_rd;
    d   = (g == 1) ? req1_data : req0_data;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
      mdl_last = 1;
      mdl_we   = 1'b0;
      mdl_a3   = '0;
      mdl_wd   = '0;
    end else begin
      if (mdl_we && mdl_a3 != 0) mdl_busy[mdl_a3] = 1'b0;
      if (iv && ir && iw && ird != 0) mdl_busy[ird] = 1'b1;
      if (g >= 0) begin
        mdl_last = g;
        mdl_we   = (rd != 0);
        mdl_a3   = rd;
        mdl_wd   = d;
      end else begin
        mdl_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_wr = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1; iss_wr = 1; iss_rd = rd; iss_rs1 = 0; iss_rs2 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    tick();
    tick();
    reset = 0;
    iss_wr = 1; iss_rd = 5'($urandom_range(0, 31));
    iss_rs1 = 5'($urandom_range(0, 31)); iss_rs2 = 5'($urandom_range(0, 31));
    #1;
    tests++; if (busy !== 32'd0) begin fails++; $display("FAIL reset_busy got %h want 0", busy); end
    tests++; if (we3 !== 1'b0) begin fails++; $display("FAIL reset_we3 got %b want 0", we3); end
    tests++; if (a3 !== 5'd0) begin fails++; $display("FAIL reset_a3 got %0d want 0", a3); end
    tests++; if (wd3 !== 32'd0) begin fails++; $display("FAIL reset_wd3 got %h want 0", wd3); end
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL reset_iss_ready got %b want 1", iss_ready); end
    $display("[TB] reset: busy=%h we3=%b", busy, we3);
    idle();
  endtask

  task automatic test_single_write();
    do_reset();
    req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", req0_ready); end
    tick();
    req0_valid = 0;
    tests++; if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_write got we3=%b a3=%0d wd3=%h want 1/5/deadbeef", we3, a3, wd3); end
    tick();
    tests++; if (we3 !== 1'b0) begin fails++; $display("FAIL single_we3_drop got %b want 0", we3); end
    $display("[TB] single write a3=5 wd3=deadbeef");
  endtask

  task automatic test_contention();
    int exp_g[4]  = '{0, 1, 0, 1};
    int exp_a3[4] = '{1, 9, 2, 10};
    int i0 = 0, i1 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1; req0_rd = 5'(1 + i0); req0_data = 32'h100 + 32'(i0);
      req1_valid = 1; req1_rd = 5'(9 + i1); req1_data = 32'h200 + 32'(i1);
      #1;
      tests++; if (req0_ready !== (exp_g[k] == 0) || req1_ready !== (exp_g[k] == 1)) begin
        fails++; $display("FAIL contention_grant[%0d] got r0=%b r1=%b want grant %0d", k, req0_ready, req1_ready, exp_g[k]); end
      tick();
      tests++; if (we3 !== 1'b1 || a3 !== 5'(exp_a3[k])) begin
        fails++; $display("FAIL contention_a3[%0d] got we3=%b a3=%0d want 1/%0d", k, we3, a3, exp_a3[k]); end
      $display("[TB] contention cycle %0d grant=%0d a3=%0d", k, exp_g[k], a3);
      if (exp_g[k] == 0) i0++; else i1++;
    end
    idle();
    tick();
  endtask

  task automatic test_raw();
    do_reset();
    issue(7);
    #1;
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL raw_first_issue got %b want 1", iss_ready); end
    tick();
    iss_wr = 0; iss_rd = 0; iss_rs1 = 7;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL raw_stall[%0d] got %b want 0", k, iss_ready); end
      tick();
    end
    req1_valid = 1; req1_rd = 7; req1_data = 32'h7777_0007;
    #1;
    tests++; if (req1_ready !== 1'b1 || iss_ready !== 1'b0) begin
      fails++; $display("FAIL raw_accept got r1=%b iss=%b want 1/0", req1_ready, iss_ready); end
    tick();
    req1_valid = 0;
    #1;
    tests++; if (we3 !== 1'b1 || busy[7] !== 1'b1 || iss_ready !== 1'b0) begin
      fails++; $display("FAIL raw_we3_cycle got we3=%b busy7=%b iss=%b want 1/1/0", we3, busy[7], iss_ready); end
    tick();
    tests++; if (busy[7] !== 1'b0 || iss_ready !== 1'b1) begin
      fails++; $display("FAIL raw_release got busy7=%b iss=%b want 0/1", busy[7], iss_ready); end
    $display("[TB] raw x7 released");
    idle();
  endtask

  task automatic test_waw();
    do_reset();
    issue(3);
    tick();
    issue(3);
    #1;
    tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL waw_stall got %b want 0", iss_ready); end
    iss_wr = 0; iss_rd = 3;
    #1;
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL waw_nowr got %b want 1", iss_ready); end
    iss_wr = 1; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    #1;
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL waw_x0 got %b want 1", iss_ready); end
    iss_valid = 0;
    req0_valid = 1; req0_rd = 0; req0_data = 32'h1234;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL waw_rd0_ready got %b want 1", req0_ready); end
    tick();
    req0_valid = 0;
    tests++; if (we3 !== 1'b0 || busy !== 32'h0000_0008) begin
      fails++; $display("FAIL waw_rd0_write got we3=%b busy=%h want 0/00000008", we3, busy); end
    $display("[TB] waw busy=%h", busy);
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(4);
    tick();
    issue(6);
    tick();
    iss_valid = 0;
    req0_valid = 1; req0_rd = 4; req0_data = 32'hABCD;
    tick();
    req0_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    tests++; if (we3 !== 1'b0 || busy !== 32'd0) begin
      fails++; $display("FAIL reset_mid got we3=%b busy=%h want 0/0", we3, busy); end
    req0_valid = 1; req0_rd = 1; req1_valid = 1; req1_rd = 2;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid_arb got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
    tick();
    idle();
    tick();
    $display("[TB] reset mid-operation done");
  endtask

  task automatic test_same_edge();
    do_reset();
    issue(6);
    tick();
    iss_valid = 0;
    req0_valid = 1; req0_rd = 6; req0_data = 32'h66;
    tick();
    req0_valid = 0;
    issue(8);
    tick();
    idle();
    tests++; if (busy[8] !== 1'b1 || busy[6] !== 1'b0) begin
      fails++; $display("FAIL same_edge got busy8=%b busy6=%b want 1/0", busy[8], busy[6]); end
    $display("[TB] same edge busy=%h", busy);
  endtask

  task automatic test_random();
    bit acc0 = 1, acc1 = 1;
    int g;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_rd = 5'($urandom_range(0, 7)); req0_data = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_rd = 5'($urandom_range(0, 7)); req1_data = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1)); iss_wr = 1'($urandom_range(0, 1));
      iss_rd = 5'($urandom_range(0, 7));
      iss_rs1 = 5'($urandom_range(0, 7)); iss_rs2 = 5'($urandom_range(0, 7));
      #1;
      g = mdl_grant();
      tests++; if (iss_ready !== mdl_iss_ready()) begin
        fails++; $display("FAIL rnd_iss_ready c=%0d got %b want %b", c, iss_ready, mdl_iss_ready()); end
      tests++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        fails++; $display("FAIL rnd_grant c=%0d got r0=%b r1=%b want grant %0d", c, req0_ready, req1_ready, g); end
      acc0 = (g == 0) && !reset;
      acc1 = (g == 1) && !reset;
      tick();
      tests++; if (we3 !== mdl_we || a3 !== mdl_a3 || wd3 !== mdl_wd) begin
        fails++; $display("FAIL rnd_port c=%0d got %b/%0d/%h want %b/%0d/%h", c, we3, a3, wd3, mdl_we, mdl_a3, mdl_wd); end
      tests++; if (busy !== mdl_busy_vec()) begin
        fails++; $display("FAIL rnd_busy c=%0d got %h want %h", c, busy, mdl_busy_vec()); end
      if (mdl_we) $display("[TB] rnd c=%0d write x%0d = %h", c, mdl_a3, mdl_wd);
    end
    reset = 0;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_raw();
    test_waw();
    test_reset_mid();
    test_same_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
